// File: rtl/color_history_pkg.sv
// Shared constants and FSM state type for the color history write path.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package color_history_pkg;

   localparam int FRAME_W = 640;
   localparam int FRAME_H = 480;
   localparam int COORD_W = 10;
   localparam int COLOR_W = 4;

   typedef enum logic [0:0] {
      S_CLEAR = 1'b0,
      S_RUN   = 1'b1
   } sched_state_t;

endpackage

// File: rtl/color_history_scheduler_clear_sweeper.sv
// Column-major (y inner, x outer) address counter for the clear sweep.
// Latency: new position visible the cycle after start/advance.
// Backpressure: none; it advances whenever advance is high.
module clear_sweeper
   import color_history_pkg::*;
#(
   parameter int WIDTH  = FRAME_W,
   parameter int HEIGHT = FRAME_H
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               advance,
   output logic [COORD_W-1:0] x,
   output logic [COORD_W-1:0] y,
   output logic               last
);

   localparam logic [COORD_W-1:0] X_MAX = COORD_W'(WIDTH - 1);
   localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(HEIGHT - 1);

   assign last = (x == X_MAX) && (y == Y_MAX);

   // Restart at (0,0) on start, else step y, carrying into x; wrap after the last pixel.
   always_ff @(posedge clk) begin
      if (!reset) begin
         x <= '0;
         y <= '0;
      end else if (start) begin
         x <= '0;
         y <= '0;
      end else if (advance) begin
         if (y == Y_MAX) begin
            y <= '0;
            x <= last ? '0 : x + COORD_W'(1);
         end else begin
            y <= y + COORD_W'(1);
         end
      end
   end

endmodule

// File: rtl/color_history_scheduler.sv
// Arbitrates two write requesters onto the color_history write port and runs the clear sweep.
// Latency: one cycle from accept (valid && ready) to write_en on the registered outputs.
// Backpressure: both readys low during the sweep and in a clear_req cycle; port 1 forced after STARVE_LIMIT denials.
module color_history_scheduler
   import color_history_pkg::*;
#(
   parameter int WIDTH        = FRAME_W,
   parameter int HEIGHT       = FRAME_H,
   parameter int STARVE_LIMIT = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clear_req,
   output logic               clear_busy,
   input  logic               req0_valid,
   input  logic [COORD_W-1:0] req0_x,
   input  logic [COORD_W-1:0] req0_y,
   input  logic [COLOR_W-1:0] req0_data,
   output logic               req0_ready,
   input  logic               req1_valid,
   input  logic [COORD_W-1:0] req1_x,
   input  logic [COORD_W-1:0] req1_y,
   input  logic [COLOR_W-1:0] req1_data,
   output logic               req1_ready,
   output logic [COORD_W-1:0] write_x,
   output logic [COORD_W-1:0] write_y,
   output logic [COLOR_W-1:0] write_data,
   output logic               write_en,
   output logic               oob_err
);

   localparam int SC_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_LIMIT);

   sched_state_t       state;
   logic [SC_W-1:0]    starve_cnt;
   logic [COORD_W-1:0] sw_x;
   logic [COORD_W-1:0] sw_y;
   logic               sw_last;
   logic               in_run;
   logic               arb_ok;
   logic               grant0;
   logic               grant1;
   logic [COORD_W-1:0] sel_x;
   logic [COORD_W-1:0] sel_y;
   logic [COLOR_W-1:0] sel_data;
   logic               sel_oob;

   assign in_run     = (state == S_RUN);
   assign clear_busy = (state == S_CLEAR);

   // A clear request in the same cycle as a valid wins: nobody is accepted.
   assign arb_ok  = in_run && !clear_req;
   assign grant1  = arb_ok && req1_valid && ((starve_cnt == SC_MAX) || !req0_valid);
   assign grant0  = arb_ok && req0_valid && !grant1;

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   clear_sweeper #(
      .WIDTH  (WIDTH),
      .HEIGHT (HEIGHT)
   ) u_sweeper (
      .clk     (clk),
      .reset   (reset),
      .start   (in_run && clear_req),
      .advance (state == S_CLEAR),
      .x       (sw_x),
      .y       (sw_y),
      .last    (sw_last)
   );

   // Mux the granted request and flag coordinates outside the frame.
   always_comb begin
      sel_x    = req0_x;
      sel_y    = req0_y;
      sel_data = req0_data;
      if (grant1) begin
         sel_x    = req1_x;
         sel_y    = req1_y;
         sel_data = req1_data;
      end
      sel_oob = (32'(sel_x) >= 32'(WIDTH)) || (32'(sel_y) >= 32'(HEIGHT));
   end

   // Sweep until the last pixel is issued; a clear request in run restarts the sweep.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= S_CLEAR;
      end else begin
         case (state)
            S_CLEAR: if (sw_last)   state <= S_RUN;
            S_RUN:   if (clear_req) state <= S_CLEAR;
            default:                state <= S_CLEAR;
         endcase
      end
   end

   // Count consecutive cycles port 1 waits; any grant or idle cycle forgives it.
   always_ff @(posedge clk) begin
      if (!reset) begin
         starve_cnt <= '0;
      end else if (!req1_valid || grant1) begin
         starve_cnt <= '0;
      end else if (starve_cnt != SC_MAX) begin
         starve_cnt <= starve_cnt + SC_W'(1);
      end
   end

   // Register the write port: sweep zeroes, accepted requests, or idle; out-of-frame writes are dropped.
   always_ff @(posedge clk) begin
      if (!reset) begin
         write_x    <= '0;
         write_y    <= '0;
         write_data <= '0;
         write_en   <= 1'b0;
         oob_err    <= 1'b0;
      end else if (state == S_CLEAR) begin
         write_x    <= sw_x;
         write_y    <= sw_y;
         write_data <= '0;
         write_en   <= 1'b1;
      end else if (grant0 || grant1) begin
         write_x    <= sel_x;
         write_y    <= sel_y;
         write_data <= sel_data;
         write_en   <= !sel_oob;
         if (sel_oob) oob_err <= 1'b1;
      end else begin
         write_en   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_color_history_scheduler.sv
// Directed bench for color_history_scheduler on a reduced 16x12 frame.
// Latency: checks writes one cycle after accept.
// Backpressure: checks readys against the arbitration and clear rules.
module tb_color_history_scheduler;

   localparam int W  = 16;
   localparam int H  = 12;
   localparam int N  = W * H;
   localparam int SL = 8;

   logic       clk = 1'b0;
   logic       reset;
   logic       clear_req;
   logic       clear_busy;
   logic       req0_valid, req1_valid;
   logic [9:0] req0_x, req0_y, req1_x, req1_y;
   logic [3:0] req0_data, req1_data;
   logic       req0_ready, req1_ready;
   logic [9:0] write_x, write_y;
   logic [3:0] write_data;
   logic       write_en;
   logic       oob_err;

   int checks = 0;
   int errors = 0;

   color_history_scheduler #(
      .WIDTH        (W),
      .HEIGHT       (H),
      .STARVE_LIMIT (SL)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .clear_req  (clear_req),
      .clear_busy (clear_busy),
      .req0_valid (req0_valid),
      .req0_x     (req0_x),
      .req0_y     (req0_y),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_x     (req1_x),
      .req1_y     (req1_y),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .write_x    (write_x),
      .write_y    (write_y),
      .write_data (write_data),
      .write_en   (write_en),
      .oob_err    (oob_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Observe a sweep from its first write; optional mid-sweep clear pulse; stop early at stop_at.
   task automatic sweep(input string tag, input bit pulse_mid, input int stop_at);
      for (int i = 0; i < N; i++) begin
         chk({tag, "_wr"}, {write_en, write_x, write_y, write_data},
             {1'b1, 10'(i / H), 10'(i % H), 4'h0});
         chk({tag, "_busy"}, clear_busy, (i < N - 1));
         chk({tag, "_rdy"}, {req0_ready, req1_ready}, 2'b00);
         if (i == stop_at) return;
         clear_req = pulse_mid && (i == 20);
         if (i == N - 2) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
         end
         if (i < N - 1) tick();
      end
   endtask

   initial begin
      reset = 1'b0; clear_req = 1'b0;
      req0_valid = 1'b1; req0_x = 10'd1; req0_y = 10'd1; req0_data = 4'h2;
      req1_valid = 1'b0; req1_x = '0; req1_y = '0; req1_data = '0;
      tick(); tick();

      // Reset state; ready stays low in S_CLEAR even with a valid request.
      chk("rst_wen", write_en, 1'b0);
      chk("rst_busy", clear_busy, 1'b1);
      chk("rst_rdy0", req0_ready, 1'b0);
      chk("rst_oob", oob_err, 1'b0);
      chk("rst_wxy", {write_x, write_y, write_data}, 24'h0);

      req0_valid = 1'b0;
      reset = 1'b1;
      tick();
      sweep("sweep1", 1'b0, -1);
      tick();
      chk("post_sweep_idle", {write_en, clear_busy}, 2'b00);

      // Both valid continuously: 8 grants to port 0, then one to port 1, repeating.
      req0_valid = 1'b1; req0_x = 10'd10; req0_y = 10'd5; req0_data = 4'h3;
      req1_valid = 1'b1; req1_x = 10'd12; req1_y = 10'd7; req1_data = 4'h5;
      for (int k = 0; k < 18; k++) begin
         logic g1;
         g1 = ((k % 9) == 8);
         #1;
         chk("arb_rdy", {req0_ready, req1_ready}, {!g1, g1});
         tick();
         if (g1) chk("arb_wr", {write_en, write_x, write_y, write_data}, {1'b1, 10'd12, 10'd7, 4'h5});
         else    chk("arb_wr", {write_en, write_x, write_y, write_data}, {1'b1, 10'd10, 10'd5, 4'h3});
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick();
      chk("arb_idle", write_en, 1'b0);

      // Port 1 alone at the far corner of the frame.
      req1_valid = 1'b1; req1_x = 10'(W - 1); req1_y = 10'(H - 1); req1_data = 4'hF;
      #1;
      chk("corner_rdy", {req0_ready, req1_ready}, 2'b01);
      tick();
      req1_valid = 1'b0;
      chk("corner_wr", {write_en, write_x, write_y, write_data}, {1'b1, 10'(W - 1), 10'(H - 1), 4'hF});
      chk("corner_oob", oob_err, 1'b0);

      // Out-of-range x then y: accepted, dropped, sticky error.
      req0_valid = 1'b1; req0_x = 10'(W); req0_y = 10'd0; req0_data = 4'h1;
      #1;
      chk("oobx_rdy", req0_ready, 1'b1);
      tick();
      req0_valid = 1'b0;
      chk("oobx_wen", write_en, 1'b0);
      chk("oobx_err", oob_err, 1'b1);
      req1_valid = 1'b1; req1_x = 10'd0; req1_y = 10'(H); req1_data = 4'h2;
      #1;
      chk("ooby_rdy", req1_ready, 1'b1);
      tick();
      req1_valid = 1'b0;
      chk("ooby_wen", write_en, 1'b0);
      tick();
      chk("oob_sticky", oob_err, 1'b1);

      // In-flight write completes, then clear beats a simultaneous valid.
      req0_valid = 1'b1; req0_x = 10'd2; req0_y = 10'd3; req0_data = 4'h9;
      tick();
      req0_x = 10'd1; req0_y = 10'd1; req0_data = 4'h7;
      req1_valid = 1'b1;
      clear_req = 1'b1;
      #1;
      chk("clr_inflight", {write_en, write_x, write_y, write_data}, {1'b1, 10'd2, 10'd3, 4'h9});
      chk("clr_rdy", {req0_ready, req1_ready}, 2'b00);
      tick();
      clear_req = 1'b0;
      chk("clr_busy", clear_busy, 1'b1);
      chk("clr_nowr", write_en, 1'b0);
      tick();
      sweep("sweep2", 1'b1, -1);
      chk("oob_after_clear", oob_err, 1'b1);

      // Reset in the middle of a sweep at (5,3), then a full restart from (0,0).
      tick();
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      tick();
      sweep("sweep3", 1'b0, 5 * H + 3);
      reset = 1'b0;
      tick();
      chk("midrst_wen", write_en, 1'b0);
      chk("midrst_busy", clear_busy, 1'b1);
      chk("midrst_oob", oob_err, 1'b0);
      reset = 1'b1;
      tick();
      sweep("sweep4", 1'b0, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
